// File: rtl/blink_meter_pkg.sv
// Shared definitions for the blink measurement block: FSM state encoding and
// the default counter width used with the LED flash generators.
package blink_meter_pkg;

    // FSM encoding: IDLE waits to arm, ON times the low phase, OFF the high phase
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_state_e;

    // 30 bits holds the default 600M-cycle timeout (2^29 would not)
    localparam int BLINK_CNT_W = 30;

    // Width of the wrapping measurement counter
    localparam int MEAS_CNT_W  = 4;

endpackage

// File: rtl/blink_meter_sig_debounce.sv
// Front end for the blink line: two-flop synchroniser followed by a stability
// filter. Rising and falling edges see the same 2+DEB_CYC cycle delay, so
// durations measured on the filtered level match the input exactly.
module sig_debounce #(
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_lvl,
    output logic o_fall,
    output logic o_rise
);

    localparam int              DW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DW-1:0]   LP_LAST = DW'(DEB_CYC - 1);

    if (DEB_CYC < 1) begin : g_bad_deb
        $error("sig_debounce: DEB_CYC must be at least 1");
    end

    logic          r_meta;
    logic          r_sync;
    logic [DW-1:0] r_stab;
    logic          r_lvl;
    logic          r_fall;
    logic          r_rise;

    // Two-flop synchroniser; idles high (line OFF) out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_sig;
            r_sync <= r_meta;
        end
    end

    // Accept the synchronised value after DEB_CYC consecutive differing cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stab <= '0;
            r_lvl  <= 1'b1;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            r_rise <= 1'b0;
            if (r_sync != r_lvl) begin
                if (r_stab == LP_LAST) begin
                    r_lvl  <= r_sync;
                    r_stab <= '0;
                    r_fall <= ~r_sync;
                    r_rise <= r_sync;
                end else begin
                    r_stab <= r_stab + 1'b1;
                end
            end else begin
                r_stab <= '0;
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_fall = r_fall;
    assign o_rise = r_rise;

endmodule

// File: rtl/blink_meter.sv
// Blink meter: measures ON (low) time and full period of a debounced
// active-low blink line and publishes each pair with a one-cycle strobe.
// The first falling edge only arms; a missing edge for TIMEOUT cycles flags stuck.
module blink_meter
    import blink_meter_pkg::*;
#(
    parameter int CNT_W   = BLINK_CNT_W,
    parameter int DEB_CYC = 1000,
    parameter int TIMEOUT = 600_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sig_in,
    output logic [CNT_W-1:0]      on_cycles,
    output logic [CNT_W-1:0]      period_cyc,
    output logic                  meas_vld,
    output logic [MEAS_CNT_W-1:0] meas_cnt,
    output logic                  stuck
);

    if ((CNT_W > 62) || (longint'(TIMEOUT) >= (longint'(1) << CNT_W))) begin : g_bad_width
        $error("blink_meter: TIMEOUT must be below 2^CNT_W");
    end

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

    // Saturating increment: counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic w_lvl;
    logic w_fall;
    logic w_rise;

    sig_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (sig_in),
        .o_lvl  (w_lvl),
        .o_fall (w_fall),
        .o_rise (w_rise)
    );

    blink_state_e          r_state;
    blink_state_e          w_next;
    logic                  w_to_hit;
    logic                  w_arm;
    logic                  w_publish;
    logic                  w_timeout;
    logic                  w_run;
    logic [CNT_W-1:0]      r_per_cnt;
    logic [CNT_W-1:0]      r_on_cnt;
    logic [CNT_W-1:0]      r_on_cycles;
    logic [CNT_W-1:0]      r_period_cyc;
    logic                  r_meas_vld;
    logic [MEAS_CNT_W-1:0] r_meas_cnt;
    logic                  r_stuck;

    assign w_to_hit = (r_per_cnt == LP_TIMEOUT);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: an edge in OFF beats a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_fall) w_next = ST_ON;
            ST_ON: begin
                if (w_to_hit)    w_next = ST_IDLE;
                else if (w_rise) w_next = ST_OFF;
            end
            ST_OFF: begin
                if (w_fall)        w_next = ST_ON;
                else if (w_to_hit) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM decoded actions
    always_comb begin
        w_arm     = (r_state == ST_IDLE) && w_fall;
        w_publish = (r_state == ST_OFF)  && w_fall;
        w_run     = (r_state == ST_ON) || (r_state == ST_OFF);
        w_timeout = w_run && w_to_hit && !w_publish;
    end

    // Duration counters: load 1 on each fall, on_cnt runs only while lvl is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= '0;
            r_on_cnt  <= '0;
        end else if (w_fall) begin
            r_per_cnt <= CNT_W'(1);
            r_on_cnt  <= CNT_W'(1);
        end else if (w_run && !w_timeout) begin
            r_per_cnt <= sat_inc(r_per_cnt);
            if ((r_state == ST_ON) && !w_lvl) begin
                r_on_cnt <= sat_inc(r_on_cnt);
            end
        end
    end

    // Published results, strobe, measurement count and stuck flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_on_cycles  <= '0;
            r_period_cyc <= '0;
            r_meas_vld   <= 1'b0;
            r_meas_cnt   <= '0;
            r_stuck      <= 1'b0;
        end else begin
            r_meas_vld <= w_publish;
            if (w_publish) begin
                r_on_cycles  <= r_on_cnt;
                r_period_cyc <= r_per_cnt;
                r_meas_cnt   <= r_meas_cnt + 1'b1;
            end
            if (w_arm) begin
                r_stuck <= 1'b0;
            end else if (w_timeout) begin
                r_stuck <= 1'b1;
            end
        end
    end

    assign on_cycles  = r_on_cycles;
    assign period_cyc = r_period_cyc;
    assign meas_vld   = r_meas_vld;
    assign meas_cnt   = r_meas_cnt;
    assign stuck      = r_stuck;

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter with DEB_CYC=4, TIMEOUT=1000, CNT_W=12.
module tb_blink_meter;

    localparam int CNT_W = 12;
    localparam int DEB   = 4;
    localparam int TO    = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sig_in = 1'b1;
    logic [CNT_W-1:0] on_cycles;
    logic [CNT_W-1:0] period_cyc;
    logic             meas_vld;
    logic [3:0]       meas_cnt;
    logic             stuck;

    blink_meter #(
        .CNT_W   (CNT_W),
        .DEB_CYC (DEB),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .on_cycles  (on_cycles),
        .period_cyc (period_cyc),
        .meas_vld   (meas_vld),
        .meas_cnt   (meas_cnt),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Strobe monitor: records every publish, flags wide strobes and
    // output changes that happen without a strobe.
    int   q_on[$];
    int   q_per[$];
    int   q_cnt[$];
    int   q_t[$];
    int   n_wide = 0;
    int   n_unstable = 0;
    logic prev_vld = 1'b0;
    int   prev_on = 0, prev_per = 0, prev_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (meas_vld) begin
                q_on.push_back(int'(on_cycles));
                q_per.push_back(int'(period_cyc));
                q_cnt.push_back(int'(meas_cnt));
                q_t.push_back(cyc);
                if (prev_vld) n_wide++;
            end else if (int'(on_cycles) != prev_on || int'(period_cyc) != prev_per ||
                         int'(meas_cnt) != prev_cnt) begin
                n_unstable++;
            end
        end
        prev_vld = meas_vld;
        prev_on  = int'(on_cycles);
        prev_per = int'(period_cyc);
        prev_cnt = int'(meas_cnt);
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic phase(input logic lv, input int n);
        sig_in = lv;
        wait_n(n);
    endtask

    task automatic sq(input int lo, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            phase(1'b0, lo);
            phase(1'b1, hi);
        end
    endtask

    task automatic clear_q();
        q_on.delete();
        q_per.delete();
        q_cnt.delete();
        q_t.delete();
    endtask

    task automatic do_reset();
        sig_in = 1'b1;
        rst_n  = 1'b0;
        wait_n(3);
        rst_n  = 1'b1;
        wait_n(2);
        clear_q();
    endtask

    task automatic chk_meas(input string tag, input int idx, input int on_e,
                            input int per_e, input int cnt_e);
        if (idx < q_on.size()) begin
            chk({tag, "_on"},  q_on[idx],  on_e);
            chk({tag, "_per"}, q_per[idx], per_e);
            chk({tag, "_cnt"}, q_cnt[idx], cnt_e);
        end else begin
            chk({tag, "_missing"}, q_on.size(), idx + 1);
        end
    endtask

    int t0;

    initial begin
        // Reset state
        do_reset();
        chk("rst_on",    int'(on_cycles),  0);
        chk("rst_per",   int'(period_cyc), 0);
        chk("rst_vld",   int'(meas_vld),   0);
        chk("rst_cnt",   int'(meas_cnt),   0);
        chk("rst_stuck", int'(stuck),      0);

        // 1: square wave 40/60, five falls -> four publishes
        t0 = cyc;
        sq(40, 60, 5);
        phase(1'b1, 20);
        chk("t1_n", q_on.size(), 4);
        for (int i = 0; i < 4; i++) chk_meas($sformatf("t1_%0d", i), i, 40, 100, i + 1);
        if (q_t.size() >= 2) begin
            chk("t1_lat", q_t[0] - t0, 107);
            chk("t1_gap", q_t[1] - q_t[0], 100);
        end else begin
            chk("t1_stamps", q_t.size(), 2);
        end

        // 2: 3-cycle glitches inside both phases are filtered out
        do_reset();
        for (int i = 0; i < 5; i++) begin
            phase(1'b0, 10); phase(1'b1, 3); phase(1'b0, 27);
            phase(1'b1, 20); phase(1'b0, 3); phase(1'b1, 37);
        end
        phase(1'b1, 20);
        chk("t2_n", q_on.size(), 4);
        for (int i = 0; i < 4; i++) chk_meas($sformatf("t2_%0d", i), i, 40, 100, i + 1);

        // 3: changing period 100/150/200 with 50-cycle low
        do_reset();
        phase(1'b0, 50); phase(1'b1, 50);
        phase(1'b0, 50); phase(1'b1, 100);
        phase(1'b0, 50); phase(1'b1, 150);
        phase(1'b0, 50); phase(1'b1, 30);
        chk("t3_n", q_on.size(), 3);
        chk_meas("t3_0", 0, 50, 100, 1);
        chk_meas("t3_1", 1, 50, 150, 2);
        chk_meas("t3_2", 2, 50, 200, 3);

        // 4: timeout. Input fall at offset 0 -> lvl fall after edge 6,
        //    per_cnt hits 1000 after edge 1006, stuck visible after edge 1007
        do_reset();
        phase(1'b0, 50);
        phase(1'b1, 956);
        chk("t4_stuck_before", int'(stuck), 0);
        phase(1'b1, 1);
        chk("t4_stuck_at", int'(stuck), 1);
        phase(1'b1, 193);
        chk("t4_stuck_hold", int'(stuck), 1);
        chk("t4_no_vld", q_on.size(), 0);
        chk("t4_on_held", int'(on_cycles), 0);
        phase(1'b0, 6);
        chk("t4_stuck_pre_arm", int'(stuck), 1);
        phase(1'b0, 1);
        chk("t4_stuck_clr", int'(stuck), 0);
        phase(1'b0, 33);
        phase(1'b1, 60);
        sq(40, 60, 2);
        phase(1'b1, 20);
        chk("t4_n", q_on.size(), 2);
        chk_meas("t4_0", 0, 40, 100, 1);
        chk_meas("t4_1", 1, 40, 100, 2);

        // 5: reset 20 cycles into a low phase; the low phase ends while in reset
        do_reset();
        sq(40, 60, 2);
        phase(1'b0, 20);
        chk("t5_pre_n", q_on.size(), 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_on",    int'(on_cycles),  0);
        chk("t5_rst_per",   int'(period_cyc), 0);
        chk("t5_rst_vld",   int'(meas_vld),   0);
        chk("t5_rst_cnt",   int'(meas_cnt),   0);
        chk("t5_rst_stuck", int'(stuck),      0);
        wait_n(2);
        rst_n  = 1'b1;
        clear_q();
        phase(1'b1, 60);
        phase(1'b0, 40); phase(1'b1, 60);
        chk("t5_arm_no_vld", q_on.size(), 0);
        sq(40, 60, 2);
        phase(1'b1, 20);
        chk("t5_n", q_on.size(), 2);
        chk_meas("t5_0", 0, 40, 100, 1);
        chk_meas("t5_1", 1, 40, 100, 2);

        // 6: meas_cnt wraps 15 -> 0
        do_reset();
        sq(20, 30, 18);
        phase(1'b1, 20);
        chk("t6_n", q_on.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < q_cnt.size()) chk($sformatf("t6_cnt%0d", i), q_cnt[i], (i + 1) % 16);
        end
        chk_meas("t6_last", 16, 20, 50, 1);

        // Strobe width and hold-between-strobes over the whole run
        chk("vld_width", n_wide, 0);
        chk("out_hold",  n_unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
